// File: rtl/box_anim_controller.sv
// box_anim_controller: sequences the bouncing-box animation onto the VGA plot port.
// The box is drawn at the tracked position, held for FRAMES_PER_MOVE frames, then
// erased. The trackers get one `move` pulse, the new position is latched and the
// box is redrawn.
// Optional build macro BOX_ANIM_PAUSE_EN adds a `pause` input that freezes the
// WAIT frame timer.
module box_anim_controller #(
  parameter int unsigned FRAME_TICKS     = 833333,
  parameter int unsigned FRAMES_PER_MOVE = 15,
  parameter int unsigned BOX_SIZE        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
`ifdef BOX_ANIM_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [2:0] colour_in,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  output logic       move,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       busy
);

  localparam int unsigned SIDE_BITS = $clog2(BOX_SIZE);
  localparam int unsigned PW        = (SIDE_BITS == 0) ? 1 : 2 * SIDE_BITS;
  localparam int unsigned TW        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [PW-1:0] PIX_LAST   = PW'(BOX_SIZE * BOX_SIZE - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAMES_PER_MOVE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAW   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ERASE  = 3'd3;
  localparam logic [2:0] S_MOVE   = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [PW-1:0] pix_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    frame_cnt;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [2:0]    colour_reg;

  logic          pix_last;
  logic          tick_last;
  logic          frame_last;
  logic          hold_timer;
  logic [7:0]    col_off;
  logic [6:0]    row_off;

  // Timer freeze request; tied off when the pause feature is not built in.
`ifdef BOX_ANIM_PAUSE_EN
  always_comb hold_timer = pause;
`else
  always_comb hold_timer = 1'b0;
`endif

  // Pixel offsets within the box: low bits select the column, high bits the row.
  always_comb begin
    col_off    = 8'(pix_cnt % PW'(BOX_SIZE));
    row_off    = 7'(pix_cnt / PW'(BOX_SIZE));
    pix_last   = (pix_cnt == PIX_LAST);
    tick_last  = (tick_cnt == TICK_LAST);
    frame_last = (frame_cnt == FRAME_LAST);
  end

  // Next-state selection; go only matters in IDLE and WAIT.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (go) state_next = S_DRAW;
      S_DRAW:   if (pix_last) state_next = S_WAIT;
      S_WAIT: begin
        if (!go)
          state_next = S_IDLE;
        else if (!hold_timer && tick_last && frame_last)
          state_next = S_ERASE;
      end
      S_ERASE:  if (pix_last) state_next = S_MOVE;
      S_MOVE:   state_next = S_SETTLE;
      S_SETTLE: state_next = S_DRAW;
      default:  state_next = S_IDLE;
    endcase
  end

  // State, counters, position latches and registered plot/move/busy outputs.
  // move and busy are decoded from state_next so they line up with the state
  // register; the pixel outputs trail the state register by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      move       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      busy       <= 1'b0;
      pix_cnt    <= '0;
      tick_cnt   <= '0;
      frame_cnt  <= '0;
      base_x     <= '0;
      base_y     <= '0;
      colour_reg <= '0;
    end else begin
      state <= state_next;
      move  <= (state_next == S_MOVE);
      busy  <= (state_next != S_IDLE) && (state_next != S_WAIT);
      plot  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            base_x     <= x_pos;
            base_y     <= y_pos;
            colour_reg <= colour_in;
            pix_cnt    <= '0;
          end
        end
        S_DRAW, S_ERASE: begin
          plot       <= 1'b1;
          vga_x      <= base_x + col_off;
          vga_y      <= base_y + row_off;
          vga_colour <= (state == S_DRAW) ? colour_reg : 3'b000;
          pix_cnt    <= pix_last ? '0 : pix_cnt + PW'(1);
          if (state == S_DRAW && pix_last) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (go && !hold_timer) begin
            if (tick_last) begin
              tick_cnt  <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              if (frame_last) pix_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        S_SETTLE: begin
          base_x     <= x_pos;
          base_y     <= y_pos;
          colour_reg <= colour_in;
          pix_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/box_anim_controller.md
Name: box_anim_controller

Overview:
- Sequences the bouncing-box animation on the VGA adapter.
- Draws a BOX_SIZE x BOX_SIZE box at the tracked position, then waits a programmable number of frames.
- After the wait: erases the box, pulses `move` once to the external X/Y position trackers, latches their new outputs and redraws.
- Sits between the position trackers and the vga_adapter plot interface.

Parameters:
- FRAME_TICKS, 833333: clock cycles per frame (50 MHz / 60 Hz).
- FRAMES_PER_MOVE, 15: frames waited between moves; legal range 1..255.
- BOX_SIZE, 4: box edge in pixels; power of two, 1..8.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- go  in  1  level; high runs the animation.
- colour_in  in  3  box colour, latched on IDLE->DRAW and on each SETTLE.
- x_pos  in  8  current X from the X position tracker.
- y_pos  in  7  current Y from the Y position tracker.
- move  out  1  one-cycle pulse that advances the trackers.
- plot  out  1  VGA write enable.
- vga_x  out  8  pixel X.
- vga_y  out  7  pixel Y.
- vga_colour  out  3  pixel colour.
- busy  out  1  high in every state except IDLE and WAIT.

Behaviour:
- One clock domain. All state, counters and outputs are registered. Reset is synchronous, active-high, and overrides everything including mid-DRAW/ERASE.
- Reset values: state=IDLE; move=0, plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0; pixel, tick and frame counters=0; base_x=0, base_y=0, colour_reg=0.
- States: IDLE, DRAW, WAIT, ERASE, MOVE, SETTLE.
- IDLE -> DRAW when go=1.
  - On that edge: base_x<=x_pos, base_y<=y_pos, colour_reg<=colour_in, pix_cnt<=0.
- DRAW and ERASE each last exactly BOX_SIZE^2 cycles (16 at default).
  - Each cycle the registered outputs update: plot=1, vga_x=base_x+pix_cnt[col], vga_y=base_y+pix_cnt[row].
  - Columns are the low log2(BOX_SIZE) bits, rows the high bits, raster order.
  - Adds are modulo 2^8 (X) and 2^7 (Y). No clamping; trackers keep the box on screen (X<=156, Y<=116 at default size).
  - Colour: DRAW drives colour_reg; ERASE drives 3'b000.
  - Plot pulses lag the state register by one cycle. `plot` goes low the cycle after the last pixel.
- DRAW last pixel -> WAIT; tick_cnt and frame_cnt cleared on entry.
- WAIT:
  - tick_cnt counts 0..FRAME_TICKS-1 and wraps; each wrap increments frame_cnt.
  - On the wrap where frame_cnt==FRAMES_PER_MOVE-1 -> ERASE with pix_cnt<=0.
  - go=0 in WAIT -> IDLE immediately; the box stays on screen and is not erased.
  - go is ignored in every other state; a running DRAW/ERASE/MOVE/SETTLE sequence always completes.
- ERASE last pixel -> MOVE.
  - MOVE: move=1 for exactly one cycle -> SETTLE.
  - SETTLE: one cycle, move=0. Trackers update on the move rising edge, so x_pos/y_pos are stable here.
  - SETTLE latches base_x, base_y and colour_in -> DRAW with pix_cnt<=0.
- One full move cycle: 16 draw + FRAME_TICKS*FRAMES_PER_MOVE wait + 16 erase + 2 cycles.
- move is never asserted outside MOVE; plot is never asserted outside DRAW/ERASE output cycles.

Optional Feature:
- Macro: BOX_ANIM_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause=1 in WAIT, tick_cnt and frame_cnt hold their values; counting resumes on release with no lost or extra ticks.
  - pause has no effect in any other state.
  - go=0 still exits WAIT to IDLE while paused.
- Undefined: no `pause` port; WAIT counts unconditionally.

Test Plan:
Sim parameters: FRAME_TICKS=4, FRAMES_PER_MOVE=2, BOX_SIZE=4.
1. Reset then go=1, x_pos=10, y_pos=20, colour_in=3'b100 -> exactly 16 plot cycles covering (10..13, 20..23) in raster order, colour 3'b100; busy=1 throughout DRAW.
2. After DRAW, hold go=1 -> plot=0 for exactly 8 cycles, then 16 ERASE plots at (10..13, 20..23) colour 000, then one move pulse. Tracker model returns x=11, y=21 -> next DRAW at (11..14, 21..24).
3. Drop go to 0 mid-WAIT -> next cycle state=IDLE, no ERASE, no move; go=1 again -> DRAW at the new x_pos/y_pos.
4. Assert reset during the 7th ERASE pixel -> next cycle all outputs 0, state IDLE, no move pulse; go=1 restarts with a fresh DRAW.
5. x_pos=156, y_pos=116 -> last pixel (159,119); x_pos=254 -> vga_x wraps to 0 and 1 (modulo check).
6. With BOX_ANIM_PAUSE_EN: pause=1 for 10 cycles in WAIT -> WAIT lasts 18 cycles; without the macro, the same stimulus gives a WAIT of 8 cycles.
